fifo_rd_stream: RTL and testbench

- Read-side adapter that sits directly downstream of the async FIFO's B-side port, in the B clock domain.
- Converts the FIFO's rd_en/empty/dout interface (1-cycle read latency) into a registered valid/ready stream.
- Uses a small prefetch buffer so a continuously-ready consumer sees one word per cycle with no bubbles.

---
 rtl/fifo_rd_pkg.sv | 12 +
 rtl/fifo_rd_buf.sv | 55 +++++
 rtl/fifo_rd_stream.sv | 82 ++++++++
 tb/tb_fifo_rd_stream.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the FIFO read-side stream adapter.
package fifo_rd_pkg;

  localparam int MIN_FULL_RATE_DEPTH = 3;

  typedef logic [31:0] perf_cnt_t;

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Circular prefetch storage with registered head word and occupancy.
// Pointers wrap explicitly at DEPTH-1, so any depth (not only powers of two) works.
module fifo_rd_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wr_en,
  input  logic [DATA_WIDTH-1:0]   i_wr_dat,
  input  logic                    i_pop,
  output logic [DATA_WIDTH-1:0]   o_head_dat,
  output logic [lvl_w(DEPTH)-1:0] o_count
);

  localparam int            PW   = $clog2(DEPTH);
  localparam int            LW   = lvl_w(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr_en) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)   r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_wr_en, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed while r_count != 0.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_dat;
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO rd_en/empty/dout (1-cycle latency) to registered valid/ready stream; pop at t gives m_valid at t+2.
// Pops are issued from occupancy only, never from m_ready; FIFO_RD_STREAM_PERF_EN adds beat/stall counters.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int SKID_DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fifo_empty,
  output logic                         fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]        fifo_dout,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [lvl_w(SKID_DEPTH)-1:0] level
`ifdef FIFO_RD_STREAM_PERF_EN
  ,
  output perf_cnt_t                    beat_cnt,
  output perf_cnt_t                    stall_cnt
`endif
);

  localparam int LW = lvl_w(SKID_DEPTH);

  logic          r_inflight;
  logic [LW-1:0] w_count;
  logic [LW:0]   w_committed;
  logic          w_pop;

  // Words already held plus the one still coming back from the FIFO.
  assign w_committed = {1'b0, w_count} + {{LW{1'b0}}, r_inflight};
  assign fifo_rd_en  = !rst && !fifo_empty && (w_committed < (LW+1)'(SKID_DEPTH));
  assign m_valid     = (w_count != '0);
  assign w_pop       = m_valid && m_ready;
  assign level       = w_count;

  always_ff @(posedge clk) begin
    if (rst) r_inflight <= 1'b0;
    else     r_inflight <= fifo_rd_en;
  end

  fifo_rd_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (SKID_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (r_inflight),
    .i_wr_dat   (fifo_dout),
    .i_pop      (w_pop),
    .o_head_dat (m_data),
    .o_count    (w_count)
  );

`ifdef FIFO_RD_STREAM_PERF_EN
  perf_cnt_t r_beat_cnt;
  perf_cnt_t r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop)               r_beat_cnt  <= r_beat_cnt + 1'b1;
      if (m_valid && !m_ready) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign beat_cnt  = r_beat_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

`ifndef SYNTHESIS
  a_no_overcommit: assert property (@(posedge clk) disable iff (rst)
    w_committed <= (LW+1)'(SKID_DEPTH));
  a_no_write_full: assert property (@(posedge clk) disable iff (rst)
    !(r_inflight && (w_count == LW'(SKID_DEPTH))));
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: cycle table for the first burst, queue scoreboard for ordering and hold,
// depth-3 instance for directed cases and a depth-5 instance under random backpressure.
module tb_fifo_rd_stream;
  import fifo_rd_pkg::*;

  localparam int DW = 64;
  localparam int DA = 3;
  localparam int DB = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic                 a_qempty, a_force, a_empty, a_rd_en, a_valid, a_ready;
  logic [DW-1:0]        a_dout, a_data;
  logic [lvl_w(DA)-1:0] a_level;
  logic                 b_qempty, b_force, b_empty, b_rd_en, b_valid, b_ready;
  logic [DW-1:0]        b_dout, b_data;
  logic [lvl_w(DB)-1:0] b_level;
  assign a_empty = a_qempty | a_force;
  assign b_empty = b_qempty | b_force;
`ifdef FIFO_RD_STREAM_PERF_EN
  perf_cnt_t a_beat_cnt, a_stall_cnt, b_beat_cnt, b_stall_cnt;
`endif

  fifo_rd_stream #(.DATA_WIDTH(DW), .SKID_DEPTH(DA)) u_dut_a (
    .clk(clk), .rst(rst), .fifo_empty(a_empty), .fifo_rd_en(a_rd_en), .fifo_dout(a_dout),
    .m_valid(a_valid), .m_ready(a_ready), .m_data(a_data), .level(a_level)
`ifdef FIFO_RD_STREAM_PERF_EN
    , .beat_cnt(a_beat_cnt), .stall_cnt(a_stall_cnt)
`endif
  );

  fifo_rd_stream #(.DATA_WIDTH(DW), .SKID_DEPTH(DB)) u_dut_b (
    .clk(clk), .rst(rst), .fifo_empty(b_empty), .fifo_rd_en(b_rd_en), .fifo_dout(b_dout),
    .m_valid(b_valid), .m_ready(b_ready), .m_data(b_data), .level(b_level)
`ifdef FIFO_RD_STREAM_PERF_EN
    , .beat_cnt(b_beat_cnt), .stall_cnt(b_stall_cnt)
`endif
  );

  // FIFO contents (a_q/b_q) and the order the consumer must see them in (a_exp/b_exp).
  logic [DW-1:0] a_q[$], a_exp[$], b_q[$], b_exp[$];
  int            n_vec = 0;
  int            n_bad = 0;
  int            a_beats, b_beats, a_pops, b_pops;
  logic          a_do_pop, b_do_pop, a_prev_stall, b_prev_stall;
  logic [DW-1:0] a_prev_data, b_prev_data;

  typedef struct {
    logic          rst;
    logic          rdy;
    logic          rd_en;
    logic          vld;
    logic [DW-1:0] dat;
    logic [1:0]    lvl;
  } vec_t;
  vec_t vec[9];

  function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endfunction

  task automatic mon_a();
    if (a_prev_stall) begin
      chk("a_hold_valid", DW'(a_valid), 64'd1);
      chk("a_hold_data", a_data, a_prev_data);
    end
    if (a_valid && a_ready) begin
      chk("a_beat_expected", DW'(a_exp.size() != 0), 64'd1);
      if (a_exp.size() != 0) chk("a_order", a_data, a_exp.pop_front());
      a_beats++;
    end
    a_prev_stall = a_valid && !a_ready;
    a_prev_data  = a_data;
  endtask

  task automatic mon_b();
    if (b_prev_stall) begin
      chk("b_hold_valid", DW'(b_valid), 64'd1);
      chk("b_hold_data", b_data, b_prev_data);
    end
    if (b_valid && b_ready) begin
      chk("b_beat_expected", DW'(b_exp.size() != 0), 64'd1);
      if (b_exp.size() != 0) chk("b_order", b_data, b_exp.pop_front());
      b_beats++;
    end
    b_prev_stall = b_valid && !b_ready;
    b_prev_data  = b_data;
  endtask

  task automatic sample();
    @(negedge clk);
    a_do_pop = a_rd_en && !a_empty;
    b_do_pop = b_rd_en && !b_empty;
    if (rst) begin
      a_prev_stall = 1'b0;
      b_prev_stall = 1'b0;
    end else begin
      mon_a();
      mon_b();
    end
  endtask

  // FIFO read port: a pop seen before the edge presents its word one cycle later.
  task automatic advance();
    @(posedge clk);
    #1;
    if (a_do_pop && a_q.size() != 0) begin a_dout = a_q.pop_front(); a_pops++; end
    if (b_do_pop && b_q.size() != 0) begin b_dout = b_q.pop_front(); b_pops++; end
    a_qempty = (a_q.size() == 0);
    b_qempty = (b_q.size() == 0);
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic flush_a();
    a_q.delete(); a_exp.delete(); a_pops = 0; a_beats = 0; a_force = 1'b0;
  endtask

  task automatic flush_b();
    b_q.delete(); b_exp.delete(); b_pops = 0; b_beats = 0; b_force = 1'b0;
  endtask

  task automatic push_a(input logic [DW-1:0] w);
    a_q.push_back(w); a_exp.push_back(w);
  endtask

  task automatic push_b(input logic [DW-1:0] w);
    b_q.push_back(w); b_exp.push_back(w);
  endtask

  initial begin
    //        rst   rdy   rd_en vld   data    level
    vec[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 2'd0};
    vec[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 2'd0};
    vec[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 2'd0};
    vec[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h1, 2'd1};
    vec[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h2, 2'd1};
    vec[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h3, 2'd1};
    vec[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 64'h4, 2'd1};
    vec[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 64'h5, 2'd1};
    vec[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 2'd0};

    rst = 1'b1; a_ready = 1'b1; b_ready = 1'b0;
    a_dout = '0; b_dout = '0; a_qempty = 1'b1; b_qempty = 1'b1;
    a_do_pop = 1'b0; b_do_pop = 1'b0; a_prev_stall = 1'b0; b_prev_stall = 1'b0;
    a_prev_data = '0; b_prev_data = '0; b_pops = 0;
    flush_a(); flush_b();
    step(); step();

    // Preloaded FIFO, reset release, free-running consumer.
    for (int i = 1; i <= 5; i++) push_a(DW'(i));
    step();
    for (int r = 0; r < 9; r++) begin
      rst = vec[r].rst; a_ready = vec[r].rdy;
      sample();
      chk($sformatf("t1_rd_en[%0d]", r), DW'(a_rd_en), DW'(vec[r].rd_en));
      chk($sformatf("t1_valid[%0d]", r), DW'(a_valid), DW'(vec[r].vld));
      chk($sformatf("t1_level[%0d]", r), DW'(a_level), DW'(vec[r].lvl));
      if (vec[r].vld) chk($sformatf("t1_data[%0d]", r), a_data, vec[r].dat);
      advance();
    end

    // Consumer stalled: prefetch stops at depth, head word held.
    rst = 1'b1; a_ready = 1'b0; flush_a(); step();
    for (int i = 0; i < 10; i++) push_a(64'h100 + DW'(i));
    step(); rst = 1'b0;
    repeat (8) step();
    chk("t2_pops", DW'(a_pops), 64'd3);
    chk("t2_rd_en", DW'(a_rd_en), 64'd0);
    chk("t2_level", DW'(a_level), 64'd3);
    chk("t2_valid", DW'(a_valid), 64'd1);
    chk("t2_head", a_data, 64'h100);
    repeat (3) step();
    chk("t2_head_stable", a_data, 64'h100);
    a_ready = 1'b1;
    for (int n = 0; n < 100 && a_beats < 10; n++) step();
    chk("t2_beats", DW'(a_beats), 64'd10);
    chk("t2_left", DW'(a_exp.size()), 64'd0);

    // fifo_empty toggling every cycle.
    rst = 1'b1; a_ready = 1'b1; flush_a(); step();
    for (int i = 0; i < 12; i++) push_a(64'h200 + DW'(i));
    step(); rst = 1'b0;
    for (int n = 0; n < 200 && a_beats < 12; n++) begin
      a_force = ~a_force;
      step();
    end
    a_force = 1'b0;
    chk("t3_beats", DW'(a_beats), 64'd12);
    chk("t3_left", DW'(a_exp.size()), 64'd0);
    repeat (4) step();
    chk("t3_idle_valid", DW'(a_valid), 64'd0);
    chk("t3_no_dup", DW'(a_beats), 64'd12);

    // Reset with two words buffered and one in flight.
    rst = 1'b1; a_ready = 1'b0; flush_a(); step();
    for (int i = 0; i < 6; i++) push_a(64'h300 + DW'(i));
    step(); rst = 1'b0;
    for (int n = 0; n < 20 && a_level != 2'd2; n++) step();
    chk("t4_level_pre", DW'(a_level), 64'd2);
    rst = 1'b1;
    sample();
    chk("t4_rd_en_in_rst", DW'(a_rd_en), 64'd0);
    flush_a();
    advance();
    rst = 1'b0;
    chk("t4_valid_post", DW'(a_valid), 64'd0);
    chk("t4_level_post", DW'(a_level), 64'd0);
    repeat (3) step();
    chk("t4_inflight_dropped", DW'(a_valid), 64'd0);

    // Depth 5, random data, random backpressure and empty gaps.
    rst = 1'b1; a_ready = 1'b0; flush_a(); flush_b(); step();
    for (int i = 0; i < 20; i++) push_b({$urandom(), $urandom()});
    step(); rst = 1'b0;
    for (int n = 0; n < 400 && b_beats < 20; n++) begin
      b_ready = 1'($urandom_range(0, 1));
      b_force = ($urandom_range(0, 3) == 0);
      step();
      chk("t5_level_bound", DW'(b_level <= 3'd5), 64'd1);
    end
    b_ready = 1'b0; b_force = 1'b0;
    chk("t5_beats", DW'(b_beats), 64'd20);
    chk("t5_left", DW'(b_exp.size()), 64'd0);

`ifdef FIFO_RD_STREAM_PERF_EN
    rst = 1'b1; a_ready = 1'b0; flush_a(); step();
    chk("perf_beat_rst", DW'(a_beat_cnt), 64'd0);
    chk("perf_stall_rst", DW'(a_stall_cnt), 64'd0);
    for (int i = 0; i < 8; i++) push_a(64'h400 + DW'(i));
    step(); rst = 1'b0;
    for (int n = 0; n < 20 && !a_valid; n++) step();
    repeat (4) step();
    a_ready = 1'b1;
    for (int n = 0; n < 100 && a_beats < 8; n++) step();
    repeat (2) step();
    chk("perf_beat_cnt", DW'(a_beat_cnt), 64'd8);
    chk("perf_stall_cnt", DW'(a_stall_cnt), 64'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
